uart_rx_ovs: RTL and testbench
==============================

UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 Parameter WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter FCLK, default 50000000, clock frequency in Hz.
REQ-003 Parameter FBAUD, default 115200, baud rate in bit/s.
REQ-004 Parameter OVS, default 16, oversampling ticks per bit; legal values 8 or 16.
REQ-005 Parameter STOP_BITS, default 1, number of stop bits checked; legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 4, receive FIFO entries; legal values are powers of two, 2..16.
REQ-007 Parameter PARITY_ODD, default 0, selects even (0) or odd (1) parity; only has effect with UART_RX_PARITY_EN.
REQ-008 Port clk50m, input, 1, sole clock; all logic is on the rising edge.
REQ-009 Port rst_n, input, 1, asynchronous active-low reset.
REQ-010 Port rx, input, 1, asynchronous serial line; idles high.
REQ-011 Port rx_data, output, WIDTH, FIFO head word; LSB is the first bit received.
REQ-012 Port rx_valid, output, 1, FIFO is non-empty and rx_data is valid.
REQ-013 Port rx_pop, input, 1, consumer pop; effective only while rx_valid=1.
REQ-014 Port rx_idle, output, 1, receive FSM is in IDLE.
REQ-015 Port rx_frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-016 Port rx_parity_err, output, 1, one-cycle pulse on a parity mismatch; tied 0 without the macro.
REQ-017 Port rx_overrun, output, 1, sticky flag: a word was dropped because the FIFO was full.
REQ-018 Port rx_err_clr, input, 1, clears rx_overrun.
REQ-019 Port rx_count, output, $clog2(FIFO_DEPTH)+1, current FIFO fill level.

Function
REQ-020 rx SHALL pass through a 2-flop synchroniser; all decoding SHALL use the synchronised value only.
REQ-021 The tick divider SHALL reload DIV-1, with DIV = FCLK/(FBAUD*OVS) using integer division, and SHALL emit one single-cycle tick on reaching 0.
REQ-022 The divider SHALL be restarted on start-edge detection, so that ticks are phase-aligned to the frame.
REQ-023 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all unused encodings SHALL go to IDLE.
REQ-024 IDLE -> START SHALL occur on a synchronised high-to-low transition of rx.
REQ-025 Each bit SHALL be decided by a majority vote of the samples at ticks OVS/2-1, OVS/2 and OVS/2+1.
REQ-026 START: a vote of 1 is a false start and SHALL return to IDLE with no flag; a vote of 0 SHALL advance to DATA at bit end.
REQ-027 DATA SHALL shift in WIDTH bits LSB-first using a bit counter, then go to PARITY if the macro is defined, else to STOP.
REQ-028 STOP SHALL check STOP_BITS stop bits; any stop bit voting 0 SHALL raise rx_frame_err and discard the word.
REQ-029 STOP SHALL return to IDLE at the midpoint of the last stop bit; no wait for the bit end, so back-to-back frames are supported.
REQ-030 A good frame SHALL be pushed into the FIFO in the cycle IDLE is re-entered.
REQ-031 Push with the FIFO full and no simultaneous pop SHALL drop the word and set rx_overrun.
REQ-032 Push and pop in the same cycle with the FIFO full SHALL accept both, leaving the count unchanged.
REQ-033 rx_valid SHALL rise one cycle after the push; rx_data SHALL update one cycle after a pop.
REQ-034 A rx_err_clr arriving in the same cycle as a new overrun SHALL leave rx_overrun set.
REQ-035 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-036 rst_n low SHALL immediately force: FSM IDLE, FIFO empty, rx_valid=0, rx_count=0, rx_data=0, all error flags 0, synchroniser flops 1.
REQ-037 Reset mid-frame SHALL abandon the frame; the partial word SHALL NOT be pushed.

Configuration
REQ-038 With UART_RX_PARITY_EN defined, a PARITY state SHALL follow DATA; a mismatch against the PARITY_ODD rule SHALL pulse rx_parity_err and discard the word.
REQ-039 Without UART_RX_PARITY_EN, no parity bit SHALL be expected, the PARITY state and logic SHALL be absent, and rx_parity_err SHALL be tied 0.

Structure
REQ-040 Package uart_pkg SHALL hold the FSM state enum type and a divider helper function computing DIV.
REQ-041 The FIFO SHALL be a sub-module named uart_rx_fifo, parametrised by WIDTH and FIFO_DEPTH.

Verification
REQ-042 Defaults; send 0xA5 at 115200 baud (DIV=27) -> rx_valid rises, rx_data=0xA5, rx_count=1.
REQ-043 Glitch of rx low for 5 ticks while idle -> false start, no push, no error flag, rx_idle back to 1.
REQ-044 Send 0x3C with stop bit forced 0 -> rx_frame_err pulses once, rx_count stays 0.
REQ-045 FIFO_DEPTH=4; send 5 frames 0x01..0x05 with no pop -> rx_count=4, rx_overrun=1, pops return 0x01..0x04; rx_err_clr then clears rx_overrun.
REQ-046 UART_RX_PARITY_EN defined, PARITY_ODD=0; send 0x07 with parity bit 0 -> rx_parity_err pulses, no push; repeat with parity bit 1 -> rx_data=0x07.
REQ-047 Assert rst_n low during bit 4 of a frame -> all outputs at reset values; the next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and baud divider helper for the oversampling UART receiver
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } rx_state_e;
`endif

    function automatic int div_calc(input int fclk, input int fbaud, input int ovs);
        return fclk / (fbaud * ovs);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive word FIFO with drop-on-full indication
module uart_rx_fifo #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              wdata_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              rdata_o,
    output logic                          valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          drop_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full, pop_ok, push_ok;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i && (!full || pop_ok);
    assign drop_o  = push_i && full && !pop_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop_ok) count_q <= count_q - 1'b1;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
endmodule

// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - oversampling UART receiver with FIFO; optional parity via UART_RX_PARITY_EN
module uart_rx_ovs import uart_pkg::*; #(
    parameter int WIDTH      = 8,
    parameter int FCLK       = 50000000,
    parameter int FBAUD      = 115200,
    parameter int OVS        = 16,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                        clk50m,
    input  logic                        rst_n,
    input  logic                        rx,
    output logic [WIDTH-1:0]            rx_data,
    output logic                        rx_valid,
    input  logic                        rx_pop,
    output logic                        rx_idle,
    output logic                        rx_frame_err,
    output logic                        rx_parity_err,
    output logic                        rx_overrun,
    input  logic                        rx_err_clr,
    output logic [$clog2(FIFO_DEPTH):0] rx_count
);
    localparam int DIV = div_calc(FCLK, FBAUD, OVS);
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVS);
    localparam int BW  = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_RELOAD = DW'(DIV - 1);
    localparam logic [TW-1:0] T_VOTE     = TW'(OVS / 2 + 1);
    localparam logic [TW-1:0] T_END      = TW'(OVS - 1);
    localparam logic          STOP_LAST  = (STOP_BITS == 2);

    rx_state_e        state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [DW-1:0]    div_q;
    logic [TW-1:0]    tick_cnt_q;
    logic [1:0]       samp_q;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             stop_cnt_q, stop_cnt_d, stop_bad_q, stop_bad_d;
    logic             discard_q, discard_d;
    logic             frame_err_q, frame_err_d, ovr_q;
    logic             rx_s, tick, start_edge, vote, vote_tick, bit_end, push, drop;

    assign rx_s       = sync2_q;
    assign tick       = (div_q == '0);
    assign start_edge = (state_q == ST_IDLE) && prev_q && !rx_s;
    assign vote       = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);
    assign vote_tick  = tick && (tick_cnt_q == T_VOTE);
    assign bit_end    = tick && (tick_cnt_q == T_END);

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            div_q      <= DIV_RELOAD;
            tick_cnt_q <= '0;
            samp_q     <= 2'b11;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            // Restarting on the start edge keeps the sample ticks centred on each bit.
            if (start_edge) begin
                div_q      <= DIV_RELOAD;
                tick_cnt_q <= '0;
            end else if (tick) begin
                div_q      <= DIV_RELOAD;
                tick_cnt_q <= tick_cnt_q + 1'b1;
                samp_q     <= {samp_q[0], rx_s};
            end else begin
                div_q <= div_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            stop_bad_q  <= 1'b0;
            discard_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            stop_bad_q  <= stop_bad_d;
            discard_q   <= discard_d;
            frame_err_q <= frame_err_d;
            ovr_q       <= drop | (ovr_q & ~rx_err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q, parity_err_d;
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) parity_err_q <= 1'b0;
        else        parity_err_q <= parity_err_d;
    end
    assign rx_parity_err = parity_err_q;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = PARITY_ODD[0];
    assign rx_parity_err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        stop_bad_d  = stop_bad_q;
        discard_d   = discard_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: if (start_edge) begin
                state_d    = ST_START;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                stop_bad_d = 1'b0;
                discard_d  = 1'b0;
            end
            ST_START: begin
                if (vote_tick && vote) state_d = ST_IDLE;
                else if (bit_end)      state_d = ST_DATA;
            end
            ST_DATA: begin
                if (vote_tick) shreg_d = {vote, shreg_q[WIDTH-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == BW'(WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (vote_tick && ((^shreg_q ^ vote) != PARITY_ODD[0])) begin
                    parity_err_d = 1'b1;
                    discard_d    = 1'b1;
                end
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                // Leave at the midpoint of the last stop bit so a following start edge is caught.
                if (vote_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d     = ST_IDLE;
                        frame_err_d = stop_bad_q | ~vote;
                        push        = ~(stop_bad_q | ~vote) & ~discard_q;
                    end else begin
                        stop_bad_d = stop_bad_q | ~vote;
                    end
                end else if (bit_end) begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    uart_rx_fifo #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk50m),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (shreg_q),
        .pop_i   (rx_pop),
        .rdata_o (rx_data),
        .valid_o (rx_valid),
        .count_o (rx_count),
        .drop_o  (drop)
    );

    assign rx_idle      = (state_q == ST_IDLE);
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - scoreboard bench for uart_rx_ovs
module tb_uart_rx_ovs;
    localparam int DIV = 27;
    localparam int BIT = DIV * 16;

    logic       clk50m = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rx     = 1'b1;
    logic       rx_pop = 1'b0;
    logic       rx_err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_idle, rx_frame_err, rx_parity_err, rx_overrun;
    logic [2:0] rx_count;

    int         total = 0;
    int         bad   = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    logic       auto_pop = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_ovs #(
        .WIDTH(8), .FCLK(50000000), .FBAUD(115200), .OVS(16),
        .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) dut (
        .clk50m        (clk50m),
        .rst_n         (rst_n),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_pop        (rx_pop),
        .rx_idle       (rx_idle),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_overrun    (rx_overrun),
        .rx_err_clr    (rx_err_clr),
        .rx_count      (rx_count)
    );

    always #10 clk50m = ~clk50m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk50m) begin
        if (rx_frame_err)  fe_cnt++;
        if (rx_parity_err) pe_cnt++;
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk50m);
            rx_pop = 1'b0;
            if (rst_n && rx_valid && auto_pop) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got %0h want none", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", rx_data, e);
                end
                rx_pop = 1'b1;
            end
        end
    end

    task automatic wait_bits(input int n);
        repeat (n * BIT) @(negedge clk50m);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic bad_par);
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_bits(1);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^d ^ bad_par;
        wait_bits(1);
`else
        if (bad_par) $display("note: parity disabled, bad_par ignored");
`endif
        rx = stop_v;
        wait_bits(1);
        rx = 1'b1;
        wait_bits(1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk50m);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (4) @(negedge clk50m);
    endtask

    initial begin
        #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_count", rx_count, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_idle", rx_idle, 1);
        chk("rst_ovr", rx_overrun, 0);
        chk("rst_fe", rx_frame_err, 0);
        repeat (10) @(negedge clk50m);
        rst_n = 1'b1;
        repeat (10) @(negedge clk50m);

        send_frame(8'hA5, 1'b1, 1'b0);
        chk("a5_valid", rx_valid, 1);
        chk("a5_count", rx_count, 1);
        chk("a5_data", rx_data, 8'hA5);
        exp_q.push_back(8'hA5);
        auto_pop = 1'b1;
        drain();
        chk("a5_empty", rx_count, 0);

        rx = 1'b0;
        repeat (5 * DIV) @(negedge clk50m);
        rx = 1'b1;
        wait_bits(2);
        chk("glitch_idle", rx_idle, 1);
        chk("glitch_count", rx_count, 0);
        chk("glitch_fe", fe_cnt, 0);

        send_frame(8'h3C, 1'b0, 1'b0);
        wait_bits(1);
        chk("fe_pulses", fe_cnt, 1);
        chk("fe_count", rx_count, 0);
        chk("fe_idle", rx_idle, 1);

        auto_pop = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        chk("ovr_count", rx_count, 4);
        chk("ovr_flag", rx_overrun, 1);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        auto_pop = 1'b1;
        drain();
        chk("ovr_sticky", rx_overrun, 1);
        rx_err_clr = 1'b1;
        @(negedge clk50m);
        rx_err_clr = 1'b0;
        chk("ovr_clr", rx_overrun, 0);

        auto_pop = 1'b0;
        send_frame(8'h33, 1'b1, 1'b0);
        chk("pre_rst_count", rx_count, 1);
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            wait_bits(1);
        end
        rx = 1'b1;
        repeat (BIT / 2) @(negedge clk50m);
        chk("mid_busy", rx_idle, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", rx_valid, 0);
        chk("mrst_count", rx_count, 0);
        chk("mrst_data", rx_data, 0);
        chk("mrst_idle", rx_idle, 1);
        repeat (5) @(negedge clk50m);
        rst_n = 1'b1;
        wait_bits(2);
        send_frame(8'h5A, 1'b1, 1'b0);
        chk("5a_count", rx_count, 1);
        chk("5a_data", rx_data, 8'h5A);
        exp_q.push_back(8'h5A);
        auto_pop = 1'b1;
        drain();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        wait_bits(1);
        chk("par_pulses", pe_cnt, 1);
        chk("par_count", rx_count, 0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        drain();
        chk("par_pulses_good", pe_cnt, 1);
`else
        chk("par_never", pe_cnt, 0);
`endif
        chk("fe_total", fe_cnt, 1);
        chk("final_ovr", rx_overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
